bus_arbiter: RTL and testbench
==============================

# bus_arbiter

- Two-master arbiter in front of the data bus.
- Master 0 is the core load/store port; master 1 is a DMA or debug requester.
- Both share the single data-bus slave port: data memory below 0x2000, peripheral window at 0x2000 and above.
- Handles req/gnt/rvalid handshakes, selects one master per cycle and routes the fixed 1-cycle-latency read response back to the master that issued it.

## Interface

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to master 0 with starvation guard for master 1
- STARVE_LIMIT, 8, mode 1 only: consecutive cycles master 1 may be refused before it is forced to win; range 1..255

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- m0_req_i, m1_req_i  in  1  address-phase request
- m0_we_i, m1_we_i  in  1  write enable
- m0_be_i, m1_be_i  in  4  byte enables
- m0_addr_i, m1_addr_i  in  14  word/byte address as used by bus
- m0_wdata_i, m1_wdata_i  in  32  write data
- m0_gnt_o, m1_gnt_o  out  1  grant; combinational, address phase accepted this cycle
- m0_rvalid_o, m1_rvalid_o  out  1  response valid, one cycle after grant
- m0_rdata_o, m1_rdata_o  out  32  read data, valid with rvalid
- bus_we_o  out  1  to bus data_we_i
- bus_be_o  out  4  to bus data_be_i
- bus_addr_o  out  14  to bus data_addr_i
- bus_wdata_o  out  32  to bus data_wdata_i
- bus_rdata_i  in  32  from bus data_rdata_o; registered by bus, valid the cycle after address phase

## Operation

- Each cycle, at most one of m0_gnt_o/m1_gnt_o is high. A grant is only given to a requesting master.
- Winner's we/be/addr/wdata drive the bus_* outputs combinationally.
- With no grant, bus_we_o=0, bus_be_o=0, bus_addr_o=0, bus_wdata_o=0. No spurious write is possible.
- Masters hold req and attributes stable until gnt. The arbiter latches nothing from the address phase except ownership.
- Round-robin (ARB_MODE=0):
  - last_q records the last granted master; reset value is 1, so master 0 wins the first tie.
  - When both request, the master != last_q wins. A single requester always wins.
  - last_q updates only on a grant.
- Fixed priority (ARB_MODE=1):
  - Master 0 wins ties.
  - starve_q counts cycles where m1_req_i=1 and m1 is not granted. It resets to 0 on m1 grant, on m1_req_i=0, and on reset.
  - When starve_q == STARVE_LIMIT, m1 wins the next tie. The counter saturates and never wraps.
- Response tracking:
  - On a grant, resp_valid_q<=1 and resp_owner_q<=winner. With no grant, resp_valid_q<=0.
  - mX_rvalid_o = resp_valid_q & (resp_owner_q==X). rvalid is given for writes too.
  - mX_rdata_o = bus_rdata_i when mX_rvalid_o, else 0.
- Back-to-back: a new grant is allowed in the same cycle a prior response returns. Responses keep strict issue order, since there is only one in flight per cycle.

## Timing

- Grant latency: 0 cycles. gnt is asserted in the cycle req is seen, if the arbiter picks that master.
- Response: rvalid/rdata appear exactly 1 cycle after the grant cycle. Peak throughput is 1 transaction per cycle.
- Reset (rst_i=1 at an edge):
  - resp_valid_q=0, last_q=1, starve_q=0.
  - Next cycle all rvalid_o=0 and all rdata_o=0.
  - gnt_o stays combinational but forced 0 while rst_i=1.
  - A response pending at reset is dropped; no rvalid follows.
- Simultaneous request and response: the owner of the returning response may be the same master that is being granted; both are valid in one cycle.
- Master dropping req before grant: legal. No state changes, except starve_q clearing for m1.

## Test plan

1. Reset, then m0 single read of addr 0x0004 with memory word 0xDEADBEEF:
   - m0_gnt_o=1 in cycle 0.
   - Cycle 1: m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF.
   - m1 outputs all 0.
2. ARB_MODE=0, both masters request continuously for 6 cycles:
   - Grants alternate m0,m1,m0,m1,m0,m1.
   - Each rvalid lands on the matching master one cycle later.
3. ARB_MODE=1, STARVE_LIMIT=3, both request continuously:
   - Grants m0,m0,m0,m1,m0,m0,m0,m1.
   - starve_q returns to 0 after each m1 grant.
4. m1 write of 0x12345678, be=4'b0011, addr 0x0010, then m0 read of the same addr back-to-back:
   - bus_we_o=1 only in the m1 grant cycle.
   - m1_rvalid_o=1 with m1_rdata_o=0.
   - m0 read returns low halfword 0x5678 merged with prior contents.
5. No requests for 4 cycles:
   - bus_we_o, bus_be_o, bus_addr_o and bus_wdata_o are all 0.
   - No gnt or rvalid.
6. m0 granted read, rst_i asserted in the following cycle:
   - m0_rvalid_o stays 0.
   - After reset, a tie goes to m0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared data-bus slave port.
// Zero-latency grant, one-cycle response routing back to the issuing master.
module bus_arbiter #(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [13:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [13:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic [31:0] m1_rdata_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [13:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic       gnt0_s;
    logic       gnt1_s;
    logic       pick1_s;
    logic       last_q;
    logic       last_d;
    logic [7:0] starve_q;
    logic [7:0] starve_d;
    logic       resp_valid_q;
    logic       resp_valid_d;
    logic       resp_owner_q;
    logic       resp_owner_d;

    // Tie-break selection and grant generation; grants are suppressed during reset.
    always_comb begin
        if (ARB_MODE == 0) begin
            pick1_s = (last_q == 1'b0);
        end else begin
            pick1_s = (starve_q >= STARVE_MAX);
        end
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst_i) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (m0_req_i && m1_req_i) begin
            gnt0_s = ~pick1_s;
            gnt1_s = pick1_s;
        end else begin
            gnt0_s = m0_req_i;
            gnt1_s = m1_req_i;
        end
    end

    // Next-state for ownership history, starvation counter and response tracking.
    always_comb begin
        last_d = last_q;
        if (gnt0_s || gnt1_s) begin
            last_d = gnt1_s;
        end else begin
            last_d = last_q;
        end
        starve_d = starve_q;
        if (!m1_req_i || gnt1_s) begin
            starve_d = 8'd0;
        end else if (starve_q < STARVE_MAX) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end
        resp_valid_d = gnt0_s | gnt1_s;
        resp_owner_d = gnt1_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q       <= 1'b1;
            starve_q     <= 8'd0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
        end else begin
            last_q       <= last_d;
            starve_q     <= starve_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    // Route the winner's address phase to the bus; idle bus is all zeros.
    always_comb begin
        bus_we_o    = 1'b0;
        bus_be_o    = 4'd0;
        bus_addr_o  = 14'd0;
        bus_wdata_o = 32'd0;
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                bus_we_o    = m0_we_i;
                bus_be_o    = m0_be_i;
                bus_addr_o  = m0_addr_i;
                bus_wdata_o = m0_wdata_i;
            end
            2'b10: begin
                bus_we_o    = m1_we_i;
                bus_be_o    = m1_be_i;
                bus_addr_o  = m1_addr_i;
                bus_wdata_o = m1_wdata_i;
            end
            default: begin
                bus_we_o    = 1'b0;
                bus_be_o    = 4'd0;
                bus_addr_o  = 14'd0;
                bus_wdata_o = 32'd0;
            end
        endcase
    end

    assign m0_gnt_o = gnt0_s;
    assign m1_gnt_o = gnt1_s;

    // A response still in flight when reset arrives is dropped immediately.
    assign m0_rvalid_o = resp_valid_q & ~resp_owner_q & ~rst_i;
    assign m1_rvalid_o = resp_valid_q &  resp_owner_q & ~rst_i;
    assign m0_rdata_o  = m0_rvalid_o ? bus_rdata_i : 32'd0;
    assign m1_rdata_o  = m1_rvalid_o ? bus_rdata_i : 32'd0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: round-robin instance (dut0) and
// fixed-priority instance with STARVE_LIMIT=3 (dut1) on shared master stimulus.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_be = 4'd0, m1_be = 4'd0;
    logic [13:0] m0_addr = 14'd0, m1_addr = 14'd0;
    logic [31:0] m0_wdata = 32'd0, m1_wdata = 32'd0;

    logic        a_g0, a_g1, a_v0, a_v1, a_we;
    logic [31:0] a_r0, a_r1, a_wd, rdata0;
    logic [3:0]  a_be;
    logic [13:0] a_ad;
    logic        b_g0, b_g1, b_v0, b_v1, b_we;
    logic [31:0] b_r0, b_r1, b_wd, rdata1;
    logic [3:0]  b_be;
    logic [13:0] b_ad;

    logic [31:0] mem [0:4095];

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(8)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m0_gnt_o(a_g0), .m1_gnt_o(a_g1), .m0_rvalid_o(a_v0), .m1_rvalid_o(a_v1),
        .m0_rdata_o(a_r0), .m1_rdata_o(a_r1),
        .bus_we_o(a_we), .bus_be_o(a_be), .bus_addr_o(a_ad), .bus_wdata_o(a_wd),
        .bus_rdata_i(rdata0)
    );

    bus_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(3)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m0_gnt_o(b_g0), .m1_gnt_o(b_g1), .m0_rvalid_o(b_v0), .m1_rvalid_o(b_v1),
        .m0_rdata_o(b_r0), .m1_rdata_o(b_r1),
        .bus_we_o(b_we), .bus_be_o(b_be), .bus_addr_o(b_ad), .bus_wdata_o(b_wd),
        .bus_rdata_i(rdata1)
    );

    // Bus slave model: registered read, byte-enabled write, zero read data on writes.
    always @(posedge clk) begin
        if (a_we) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) mem[a_ad[13:2]][8*b +: 8] <= a_wd[8*b +: 8];
            end
        end
        rdata0 <= a_we ? 32'd0 : mem[a_ad[13:2]];
        rdata1 <= b_we ? 32'd0 : mem[b_ad[13:2]];
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'd0; m0_addr = 14'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'd0; m1_addr = 14'd0; m1_wdata = 32'd0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        next_cycle();
        @(negedge clk);
        tests_run++;
        if ({a_g0, a_g1, b_g0, b_g1} !== 4'b0000) begin
            failed++; $display("FAIL reset_gnt got %b exp 0000", {a_g0, a_g1, b_g0, b_g1});
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if ({a_v0, a_v1, b_v0, b_v1} !== 4'b0000 || (a_r0 | a_r1 | b_r0 | b_r1) !== 32'd0) begin
            failed++; $display("FAIL reset_resp rvalid=%b rdata_or=%h exp 0", {a_v0, a_v1, b_v0, b_v1}, a_r0 | a_r1 | b_r0 | b_r1);
        end
        tests_run++;
        if (dut1.starve_q !== 8'd0) begin
            failed++; $display("FAIL reset_starve got %0d exp 0", dut1.starve_q);
        end
        next_cycle();
    endtask

    task automatic test_single_read;
        m0_req = 1'b1; m0_addr = 14'h0004; m0_be = 4'hF;
        @(negedge clk);
        tests_run++;
        if (a_g0 !== 1'b1 || a_g1 !== 1'b0 || a_ad !== 14'h0004 || a_we !== 1'b0) begin
            failed++; $display("FAIL single_gnt g0=%b g1=%b addr=%h we=%b exp 1 0 0004 0", a_g0, a_g1, a_ad, a_we);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (a_v0 !== 1'b1 || a_r0 !== 32'hDEADBEEF) begin
            failed++; $display("FAIL single_resp rvalid=%b rdata=%h exp 1 deadbeef", a_v0, a_r0);
        end
        tests_run++;
        if (a_g1 !== 1'b0 || a_v1 !== 1'b0 || a_r1 !== 32'd0) begin
            failed++; $display("FAIL single_m1_quiet g1=%b v1=%b r1=%h exp 0", a_g1, a_v1, a_r1);
        end
        next_cycle();
    endtask

    task automatic test_round_robin;
        logic exp0;
        do_reset();
        m0_req = 1'b1; m0_addr = 14'h0000; m0_be = 4'hF;
        m1_req = 1'b1; m1_addr = 14'h0008; m1_be = 4'hF;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) idle_inputs();
            exp0 = ((i % 2) == 0);
            @(negedge clk);
            if (i < 6) begin
                tests_run++;
                if (a_g0 !== exp0 || a_g1 !== ~exp0) begin
                    failed++; $display("FAIL rr_gnt cyc%0d g0=%b g1=%b exp %b %b", i, a_g0, a_g1, exp0, ~exp0);
                end
            end
            if (i > 0) begin
                tests_run++;
                if (exp0) begin
                    if (a_v1 !== 1'b1 || a_v0 !== 1'b0 || a_r1 !== 32'h22222222) begin
                        failed++; $display("FAIL rr_resp cyc%0d v0=%b v1=%b r1=%h exp 0 1 22222222", i, a_v0, a_v1, a_r1);
                    end
                end else begin
                    if (a_v0 !== 1'b1 || a_v1 !== 1'b0 || a_r0 !== 32'h11111111) begin
                        failed++; $display("FAIL rr_resp cyc%0d v0=%b v1=%b r0=%h exp 1 0 11111111", i, a_v0, a_v1, a_r0);
                    end
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_fixed_priority;
        logic       exp1;
        logic [7:0] exp_starve;
        do_reset();
        m0_req = 1'b1; m0_addr = 14'h0000; m0_be = 4'hF;
        m1_req = 1'b1; m1_addr = 14'h0008; m1_be = 4'hF;
        for (int i = 0; i < 9; i++) begin
            exp1       = ((i % 4) == 3);
            exp_starve = 8'(i % 4);
            @(negedge clk);
            tests_run++;
            if (b_g1 !== exp1 || b_g0 !== ~exp1) begin
                failed++; $display("FAIL fp_gnt cyc%0d g0=%b g1=%b exp %b %b", i, b_g0, b_g1, ~exp1, exp1);
            end
            tests_run++;
            if (dut1.starve_q !== exp_starve) begin
                failed++; $display("FAIL fp_starve cyc%0d got %0d exp %0d", i, dut1.starve_q, exp_starve);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back;
        do_reset();
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b0011; m1_addr = 14'h0010; m1_wdata = 32'h12345678;
        @(negedge clk);
        tests_run++;
        if (a_g1 !== 1'b1 || a_we !== 1'b1 || a_be !== 4'b0011 || a_ad !== 14'h0010 || a_wd !== 32'h12345678) begin
            failed++; $display("FAIL b2b_write g1=%b we=%b be=%b addr=%h wd=%h exp 1 1 0011 0010 12345678", a_g1, a_we, a_be, a_ad, a_wd);
        end
        next_cycle();
        idle_inputs();
        m0_req = 1'b1; m0_addr = 14'h0010; m0_be = 4'hF;
        @(negedge clk);
        tests_run++;
        if (a_g0 !== 1'b1 || a_we !== 1'b0) begin
            failed++; $display("FAIL b2b_read_gnt g0=%b we=%b exp 1 0", a_g0, a_we);
        end
        tests_run++;
        if (a_v1 !== 1'b1 || a_r1 !== 32'd0 || a_v0 !== 1'b0) begin
            failed++; $display("FAIL b2b_wr_resp v1=%b r1=%h v0=%b exp 1 0 0", a_v1, a_r1, a_v0);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (a_v0 !== 1'b1 || a_r0 !== 32'hAABB5678 || a_we !== 1'b0) begin
            failed++; $display("FAIL b2b_rd_resp v0=%b r0=%h we=%b exp 1 aabb5678 0", a_v0, a_r0, a_we);
        end
        next_cycle();
    endtask

    task automatic test_idle;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (a_we !== 1'b0 || a_be !== 4'd0 || a_ad !== 14'd0 || a_wd !== 32'd0 ||
                b_we !== 1'b0 || b_be !== 4'd0 || b_ad !== 14'd0 || b_wd !== 32'd0) begin
                failed++; $display("FAIL idle_bus cyc%0d we=%b be=%b addr=%h wd=%h exp all 0", i, a_we, a_be, a_ad, a_wd);
            end
            tests_run++;
            if ({a_g0, a_g1, a_v0, a_v1, b_g0, b_g1, b_v0, b_v1} !== 8'd0) begin
                failed++; $display("FAIL idle_handshake cyc%0d got %b exp 00000000", i, {a_g0, a_g1, a_v0, a_v1, b_g0, b_g1, b_v0, b_v1});
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_drop;
        m0_req = 1'b1; m0_addr = 14'h0004; m0_be = 4'hF;
        @(negedge clk);
        tests_run++;
        if (a_g0 !== 1'b1) begin
            failed++; $display("FAIL drop_gnt got %b exp 1", a_g0);
        end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a_v0 !== 1'b0 || a_r0 !== 32'd0) begin
            failed++; $display("FAIL drop_rvalid_in_reset v0=%b r0=%h exp 0 0", a_v0, a_r0);
        end
        next_cycle();
        rst = 1'b0;
        m0_req = 1'b1; m0_addr = 14'h0000; m0_be = 4'hF;
        m1_req = 1'b1; m1_addr = 14'h0008; m1_be = 4'hF;
        @(negedge clk);
        tests_run++;
        if (a_v0 !== 1'b0 || a_v1 !== 1'b0) begin
            failed++; $display("FAIL drop_rvalid_after v0=%b v1=%b exp 0 0", a_v0, a_v1);
        end
        tests_run++;
        if (a_g0 !== 1'b1 || a_g1 !== 1'b0) begin
            failed++; $display("FAIL drop_tie g0=%b g1=%b exp 1 0", a_g0, a_g1);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        mem[0] = 32'h11111111;
        mem[1] = 32'hDEADBEEF;
        mem[2] = 32'h22222222;
        mem[4] = 32'hAABBCCDD;
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_back_to_back();
        test_idle();
        test_reset_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
